// File: rtl/fifo_8xnb.sv
// fifo_8xnb: 8-entry, DW-bit first-word-fall-through FIFO on a single clock.
// Read data is shown combinationally from the head entry while the FIFO is
// non-empty, and reads as zero when it is empty. Pushes while full and pops
// while empty are refused. Each refusal is reported by a one-cycle registered
// pulse.
// Optional build macro FIFO_8XNB_LEVEL_EN adds the level_o occupancy output.
module fifo_8xnb #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          ren_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          underflow_o
`ifdef FIFO_8XNB_LEVEL_EN
  ,
  output logic [AW:0]   level_o
`endif
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Flags come from the pointers. The extra wrap bit tells full apart from empty.
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    w_push  = wen_i && !w_full && !rst;
    w_pop   = ren_i && !w_empty && !rst;
  end

  // Storage is not reset. Only an accepted push writes an entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer update and refusal pulses. Reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_overflow  <= wen_i && w_full;
      r_underflow <= ren_i && w_empty;
    end
  end

  // Show-ahead read of the head entry, forced to zero when the FIFO is empty.
  always_comb begin
    rdata_o     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    full_o      = w_full;
    empty_o     = w_empty;
    overflow_o  = r_overflow;
    underflow_o = r_underflow;
  end

`ifdef FIFO_8XNB_LEVEL_EN
  // Occupancy is the modulo-16 pointer difference, giving 0..8.
  always_comb begin
    level_o = r_wptr - r_rptr;
  end
`endif

endmodule

// File: tb/tb_fifo_8xnb.sv
// tb_fifo_8xnb: directed bench with a scoreboard queue. The stimulus pushes the
// expected pop data into the queue. The monitor compares the queue against the
// DUT on every accepted pop.
module tb_fifo_8xnb;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       unf;
`ifdef FIFO_8XNB_LEVEL_EN
  logic [3:0] level;
`endif

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  fifo_8xnb #(.AW(3), .DW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .wen_i       (wen),
    .wdata_i     (wdata),
    .ren_i       (ren),
    .rdata_o     (rdata),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (ovf),
    .underflow_o (unf)
`ifdef FIFO_8XNB_LEVEL_EN
    ,
    .level_o     (level)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_level(input string nm, input logic [3:0] exp);
`ifdef FIFO_8XNB_LEVEL_EN
    chk(nm, {28'd0, level}, {28'd0, exp});
`else
    if (exp > 4'd8) $display("level expectation out of range for %s", nm);
`endif
  endtask

  // Monitor: checks every accepted pop against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && ren && !empty) begin
      pops++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_no_expect actual=%0h required=none", rdata);
      end else begin
        chk("pop_data", {24'd0, rdata}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Apply one cycle of requests. Returns 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wen   = w;
    wdata = d;
    ren   = r;
    @(negedge clk);
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00;

    // Reset, then idle.
    step(1'b1, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    chk("rst_unf",   {31'd0, unf},   32'd0);
    chk_level("rst_level", 4'd0);

    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i * 8'h11), 1'b0);
      sb.push_back(8'(i * 8'h11));
      if (i == 1) chk("first_fwft", {24'd0, rdata}, 32'h11);
    end
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_empty", {31'd0, empty}, 32'd0);
    chk("fill_head",  {24'd0, rdata}, 32'h11);
    chk_level("fill_level", 4'd8);

    // Overflow: a push of 0xAA while full must be refused.
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", {31'd0, ovf},  32'd1);
    chk("ovf_full",  {31'd0, full}, 32'd1);
    chk("ovf_head",  {24'd0, rdata}, 32'h11);
    chk_level("ovf_level", 4'd8);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", {31'd0, ovf}, 32'd0);

    // Drain: the monitor expects 0x11..0x88 and never 0xAA.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_rdata", {24'd0, rdata}, 32'd0);
    chk("drain_unf",   {31'd0, unf},   32'd0);

    // Simultaneous push and pop on an empty FIFO.
    step(1'b1, 8'h5C, 1'b1);
    sb.push_back(8'h5C);
    chk("se_unf",   {31'd0, unf},   32'd1);
    chk("se_empty", {31'd0, empty}, 32'd0);
    chk("se_rdata", {24'd0, rdata}, 32'h5C);
    chk_level("se_level", 4'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("se_unf_clear", {31'd0, unf}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("se_drained", {31'd0, empty}, 32'd1);

    // Simultaneous push and pop on a full FIFO.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      sb.push_back(8'(i));
    end
    chk("sf_full", {31'd0, full}, 32'd1);
    step(1'b1, 8'hEE, 1'b1);
    chk("sf_ovf",  {31'd0, ovf},  32'd1);
    chk("sf_full_after", {31'd0, full}, 32'd0);
    chk("sf_head", {24'd0, rdata}, 32'h02);
    chk_level("sf_level", 4'd7);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    chk("sf_drained", {31'd0, empty}, 32'd1);

    // Wrap-around: one push and one pop every cycle. Each pop returns the previous push.
    step(1'b1, 8'd0, 1'b0);
    sb.push_back(8'd0);
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b1);
      sb.push_back(8'(i));
    end
    chk("wrap_head", {24'd0, rdata}, 32'd19);
    chk_level("wrap_level", 4'd1);
    step(1'b1, 8'd20, 1'b0);
    step(1'b1, 8'd21, 1'b0);
    chk_level("pre_rst_level", 4'd3);
    chk("pre_rst_empty", {31'd0, empty}, 32'd0);

    // Reset with 3 entries held. A push in the reset cycle is discarded.
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    chk_level("mid_rst_level", 4'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_rst_unf", {31'd0, unf}, 32'd1);

    chk("total_pops", pops, 32'd36);
    chk("sb_left", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_8xnb.md
Name: fifo_8xnb

Overview:
- Synchronous 8-entry, DW-bit first-word-fall-through FIFO for bridge-side buffering, e.g. queuing AHB write data toward the APB side.
- Reads from its 8-entry storage by keeping write/read pointers and full/empty state.
- Read data is combinational from the head entry (show-ahead).
- Write and read share one clock; no CDC.

Parameters:
- AW, 3, pointer index width; depth fixed at 8 (AW must be 3).
- DW, 8, data width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- wen_i  input  1  push request
- wdata_i  input  DW  push data
- ren_i  input  1  pop request
- rdata_o  output  DW  head entry, valid when empty_o=0
- full_o  output  1  8 entries held
- empty_o  output  1  0 entries held
- overflow_o  output  1  one-cycle pulse: push refused because full
- underflow_o  output  1  one-cycle pulse: pop refused because empty

Behaviour:
- Reset, sampled on rising clk while rst=1:
  - wptr=0, rptr=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, rdata_o=0.
  - Storage contents are not reset.
  - Reset dominates wen_i and ren_i; a push or pop in the reset cycle is discarded.
- Pointers:
  - wptr and rptr are AW+1 = 4 bits; the low 3 bits index the storage, bit 3 is the wrap bit.
  - Each pointer increments by 1 modulo 16, so 7 wraps to 0 in the index with the wrap bit toggled.
- Flags are combinational from registered pointers:
  - empty_o = (wptr == rptr).
  - full_o = (wptr[2:0] == rptr[2:0]) and (wptr[3] != rptr[3]).
- Push accepted = wen_i & ~full_o, using full_o as seen in the current cycle.
  - On accept: storage[wptr[2:0]] <= wdata_i and wptr += 1.
- Pop accepted = ren_i & ~empty_o.
  - On accept: rptr += 1; the next entry appears on rdata_o in the following cycle.
- rdata_o = storage[rptr[2:0]] when empty_o=0, else 0.
  - Zero latency: the head is visible in the same cycle it becomes valid.
- Push-to-read latency: data pushed in cycle N is visible on rdata_o in cycle N+1 if the FIFO was empty. There is no write-to-read bypass.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, occupancy unchanged, pointers both advance.
  - Full: pop accepted, push refused (overflow_o=1 next cycle), result 7 entries.
  - Empty: push accepted, pop refused (underflow_o=1 next cycle), result 1 entry.
- overflow_o and underflow_o are registered, asserted for exactly the cycle after the refused request, and clear the following cycle unless the refusal repeats.
- Occupancy never exceeds 8 and never goes below 0. A refused request changes no pointer and no storage.

Optional Feature:
- Macro FIFO_8XNB_LEVEL_EN.
- Defined:
  - Adds output level_o (AW+1 = 4 bits) = wptr - rptr modulo 16, range 0..8, combinational from the pointers.
  - Reset value 0; equals 8 exactly when full_o=1.
- Not defined:
  - level_o does not exist; port list and behaviour are otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release.
  - Expect empty_o=1, full_o=0, rdata_o=0, overflow_o=0, underflow_o=0, level_o=0.
- Fill and drain (DW=8): push 0x11..0x88 on 8 consecutive cycles.
  - After the 8th push: full_o=1, level_o=8, rdata_o=0x11.
  - Pop 8 cycles: rdata_o sequence is 0x11,0x22,...,0x88, then empty_o=1 and rdata_o=0.
- Overflow: with the FIFO full, push 0xAA.
  - Expect overflow_o=1 for exactly 1 cycle, level_o stays 8.
  - Subsequent pops return 0x11..0x88; 0xAA never appears.
- Underflow and simultaneous on empty: on an empty FIFO assert wen_i=1 (0x5C) and ren_i=1 together.
  - Next cycle: underflow_o=1, empty_o=0, rdata_o=0x5C, level_o=1.
- Simultaneous on full: with the FIFO full, assert wen_i (0xEE) and ren_i together.
  - Expect overflow_o=1, level_o=7, and the head advances to the second entry.
- Wrap-around and reset mid-operation:
  - Run 20 cycles of one push plus one pop per cycle with data 0..19; each rdata_o equals the value pushed one cycle earlier, and the pointers wrap past 15.
  - Then assert rst with 3 entries held: next cycle empty_o=1, level_o=0, and a pop gives underflow_o=1.
